// File: rtl/rle_decode.sv
// Run-length decoder: reads (count,value) byte pairs over port A, expands each run and
// writes the packed plaintext back through the same port.
module rle_decode #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned MAX_OUT = 65536
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       rle_addr,
  input  logic [31:0]       rle_size,
  input  logic [31:0]       out_addr,
  output logic [31:0]       out_size,
  output logic              done,
  output logic              error,
  output logic              port_A_clk,
  output logic [ADDR_W-1:0] port_A_addr,
  output logic              port_A_we,
  output logic [31:0]       port_A_data_in,
  input  logic [31:0]       port_A_data_out
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRdReq  = 3'd1;
  localparam logic [2:0] StRdCap  = 3'd2;
  localparam logic [2:0] StExpand = 3'd3;
  localparam logic [2:0] StWr     = 3'd4;
  localparam logic [2:0] StFlush  = 3'd5;
  localparam logic [2:0] StDone   = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [31:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0] size_q, size_d, consumed_q, consumed_d, base_q, base_d;
  logic [15:0] hi_q, hi_d;
  logic        pair_q, pair_d;
  logic [7:0]  rem_q, rem_d, val_q, val_d;
  logic [31:0] pack_q, pack_d;
  logic [1:0]  pack_cnt_q, pack_cnt_d;
  logic [31:0] out_size_q, out_size_d;
  logic        error_q, error_d;

  logic [2:0]  adv_state;
  logic        adv_pair;
  logic [7:0]  adv_rem, adv_val;
  logic [32:0] cons_next;
  logic        pair0_ok, pair1_ok, more_in, wr_cycle;

  assign cons_next = {1'b0, consumed_q} + 33'd4;
  assign pair0_ok  = ({1'b0, consumed_q} + 33'd1) < {1'b0, size_q};
  assign pair1_ok  = ({1'b0, base_q} + 33'd3) < {1'b0, size_q};
  assign more_in   = consumed_q < size_q;

  // Where to go once the current run is used up: second pair of the word, next word, or flush.
  always_comb begin
    adv_pair = pair_q;
    adv_rem  = 8'd0;
    adv_val  = val_q;
    if (!pair_q && pair1_ok) begin
      adv_state = StExpand;
      adv_pair  = 1'b1;
      adv_rem   = hi_q[7:0];
      adv_val   = hi_q[15:8];
    end else begin
      adv_state = more_in ? StRdReq : StFlush;
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    size_d     = size_q;
    consumed_d = consumed_q;
    base_d     = base_q;
    hi_d       = hi_q;
    pair_d     = pair_q;
    rem_d      = rem_q;
    val_d      = val_q;
    pack_d     = pack_q;
    pack_cnt_d = pack_cnt_q;
    out_size_d = out_size_q;
    error_d    = error_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          rd_ptr_d   = {rle_addr[31:2], 2'b00};
          wr_ptr_d   = {out_addr[31:2], 2'b00};
          size_d     = rle_size;
          consumed_d = 32'd0;
          out_size_d = 32'd0;
          error_d    = 1'b0;
          pack_d     = 32'd0;
          pack_cnt_d = 2'd0;
          state_d    = (rle_size < 32'd2) ? StDone : StRdReq;
        end
      end
      StRdReq: state_d = StRdCap;
      StRdCap: begin
        hi_d       = port_A_data_out[31:16];
        base_d     = consumed_q;
        consumed_d = (cons_next > {1'b0, size_q}) ? size_q : cons_next[31:0];
        rd_ptr_d   = rd_ptr_q + 32'd4;
        pair_d     = 1'b0;
        rem_d      = pair0_ok ? port_A_data_out[7:0] : 8'd0;
        val_d      = port_A_data_out[15:8];
        state_d    = StExpand;
      end
      StExpand: begin
        if (rem_q == 8'd0) begin
          state_d = adv_state;
          pair_d  = adv_pair;
          rem_d   = adv_rem;
          val_d   = adv_val;
        end else if (out_size_q == 32'(MAX_OUT)) begin
          // Byte MAX_OUT+1 is dropped; whatever is already packed still gets written.
          error_d = 1'b1;
          state_d = StFlush;
        end else begin
          pack_d[{pack_cnt_q, 3'b000} +: 8] = val_q;
          pack_cnt_d = pack_cnt_q + 2'd1;
          out_size_d = out_size_q + 32'd1;
          rem_d      = rem_q - 8'd1;
          if (pack_cnt_q == 2'd3) begin
            state_d = StWr;
          end else if (rem_q == 8'd1) begin
            state_d = adv_state;
            pair_d  = adv_pair;
            rem_d   = adv_rem;
            val_d   = adv_val;
          end
        end
      end
      StWr: begin
        wr_ptr_d = wr_ptr_q + 32'd4;
        pack_d   = 32'd0;
        state_d  = StExpand;
        if (rem_q == 8'd0) begin
          state_d = adv_state;
          pair_d  = adv_pair;
          rem_d   = adv_rem;
          val_d   = adv_val;
        end
      end
      StFlush: begin
        if (pack_cnt_q != 2'd0) wr_ptr_d = wr_ptr_q + 32'd4;
        pack_d     = 32'd0;
        pack_cnt_d = 2'd0;
        state_d    = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      rd_ptr_q   <= 32'd0;
      wr_ptr_q   <= 32'd0;
      size_q     <= 32'd0;
      consumed_q <= 32'd0;
      base_q     <= 32'd0;
      hi_q       <= 16'd0;
      pair_q     <= 1'b0;
      rem_q      <= 8'd0;
      val_q      <= 8'd0;
      pack_q     <= 32'd0;
      pack_cnt_q <= 2'd0;
      out_size_q <= 32'd0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      size_q     <= size_d;
      consumed_q <= consumed_d;
      base_q     <= base_d;
      hi_q       <= hi_d;
      pair_q     <= pair_d;
      rem_q      <= rem_d;
      val_q      <= val_d;
      pack_q     <= pack_d;
      pack_cnt_q <= pack_cnt_d;
      out_size_q <= out_size_d;
      error_q    <= error_d;
    end
  end

  assign wr_cycle = (state_q == StWr) || ((state_q == StFlush) && (pack_cnt_q != 2'd0));

  // Gating with reset keeps a write from landing on the edge that aborts the frame.
  assign port_A_clk     = clk;
  assign port_A_we      = wr_cycle && !reset;
  assign port_A_addr    = wr_cycle ? wr_ptr_q[ADDR_W-1:0] : rd_ptr_q[ADDR_W-1:0];
  assign port_A_data_in = pack_q;
  assign done           = (state_q == StDone);
  assign error          = error_q;
  assign out_size       = out_size_q;

  logic unused_bits;
  assign unused_bits = ^{rd_ptr_q[31:ADDR_W], wr_ptr_q[31:ADDR_W], rle_addr[1:0], out_addr[1:0]};

endmodule
